sha256_round_ctrl: RTL and testbench
====================================

// Module: sha256_round_ctrl
// PURPOSE
//  Sequences the SHA-256 compression round datapath across 64 rounds for one 512-bit block.
//  Holds working regs A..H, chaining state H0..H7, round counter, Ki ROM and 16-word Wi schedule.
//  Accepts padded blocks via valid/ready, chains multi-block messages, returns 256-bit digest.
//  Sits between the message padder (upstream) and digest consumer (downstream).
// PARAMETERS
//  ROUNDS      64   rounds per block; values <64 for debug only, and digest is then non-standard
//  OUT_REG     1    1: out_digest registered in DONE; 0: driven directly from H0..H7 regs
// PORTS
//  clk          in   1    rising-edge clock
//  rst          in   1    synchronous, active-high reset
//  in_valid     in   1    in_block/in_first valid
//  in_ready     out  1    controller can accept a block (IDLE only)
//  in_block     in   512  padded block, word W0 in [511:480], big-endian words
//  in_first     in   1    1: start from IV; 0: chain from previous H0..H7
//  out_valid    out  1    digest valid, held until out_ready
//  out_ready    in   1    consumer accepts digest
//  out_digest   out  256  H0 in [255:224] .. H7 in [31:0]
//  busy         out  1    high in LOAD/ROUND/FINAL/DONE
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1, out_valid=0, busy=0, out_digest=0, rnd=0; H0..H7=IV (6a09e667..5be0cd19).
//  FSM: IDLE -(in_valid&in_ready)-> LOAD -> ROUND(xROUNDS) -> FINAL -> DONE -(out_ready)-> IDLE.
//  IDLE: in_ready=1; on accept (cycle T), latch in_block into W[0..15]; if in_first, load H0..H7 from IV.
//  LOAD (T+1): A..H <= H0..H7; rnd <= 0.
//  ROUND (T+2..T+ROUNDS+1): one round/cycle using K[rnd], Wt; rnd increments; leave after rnd==ROUNDS-1.
//   Wt = W[0] for all t; schedule shifts each round: W[15] <= s1(W[14])+W[9]+s0(W[1])+W[0].
//   T1 = H+S1(E)+Ch(E,F,G)+K+Wt; T2 = S0(A)+Maj(A,B,C); A<=T1+T2, E<=D+T1, others shift.
//  FINAL (T+ROUNDS+2): Hi <= Hi + working reg i, all mod 2^32 (carries discarded).
//  DONE (from T+ROUNDS+3): out_valid=1, out_digest stable; on out_ready -> IDLE same cycle, out_valid drops next.
//   out_valid & out_ready in same cycle as assertion is legal; latency block-accept->out_valid = ROUNDS+3.
//  Chaining: H0..H7 retained after DONE; next block with in_first=0 continues from them.
//  in_first=0 on the first block after reset uses IV (reset value) - no error.
//  in_valid while not IDLE: ignored (in_ready=0); in_block must be held by upstream until accepted.
//  out_ready while not DONE: ignored.
//  rst mid-operation (any state): immediate return to reset values; partial digest discarded, H reverts to IV.
//  All adds 32-bit wrap-around; rotations per FIPS 180-4 (S0: 2,13,22; S1: 6,11,25; s0: 7,18,>>3; s1: 17,19,>>10).
// STRUCTURE
//  Shared package: state encoding (IDLE/LOAD/ROUND/FINAL/DONE), IV[0..7], K[0..63] table,
//   S0/S1/s0/s1/Ch/Maj as functions.
//  Sub-module sha256_round: pure combinational round (A..H, Ki, Wi in; A'..H' out), full T1+T2 path.
//  Controller owns FSM, counter, W shift register, K lookup by rnd, H accumulators.
// TESTING
//  1 "abc" single block, in_first=1 -> out_digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad at T+67.
//  2 empty message (0x80, zeros, len=0) -> e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
//  3 two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", block2 in_first=0
//    -> 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
//  4 out_ready held 0 for 10 cycles in DONE -> out_valid/out_digest stable, in_ready=0, in_valid ignored.
//  5 rst at rnd=30 of "abc", then "abc" again with in_first=0 -> ba7816bf..f20015ad (IV used).
//  6 back-to-back: out_ready=1 and in_valid=1 continuously -> one block accepted every ROUNDS+4 cycles.

Source files
------------

// File: rtl/sha256_round_ctrl_pkg.sv
// Shared types, constants and FIPS 180-4 helper functions for the SHA-256 round controller.
package sha256_round_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } state_t;

  // Word a sits in the MSBs so a packed work_t lines up with the digest layout.
  typedef struct packed {
    logic [31:0] a, b, c, d, e, f, g, h;
  } work_t;

  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    logic [63:0] t;
    t = {x, x} >> n;
    return t[31:0];
  endfunction

  function automatic logic [31:0] big_sig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_round_ctrl_round.sv
// One combinational SHA-256 compression round: working regs, K and W in, next working regs out.
module sha256_round_ctrl_round
  import sha256_round_ctrl_pkg::*;
(
  input  work_t       wk,
  input  logic [31:0] k,
  input  logic [31:0] w,
  output work_t       wk_next
);

  logic [31:0] t1;
  logic [31:0] t2;

  always_comb begin
    t1 = wk.h + big_sig1(wk.e) + ch(wk.e, wk.f, wk.g) + k + w;
    t2 = big_sig0(wk.a) + maj(wk.a, wk.b, wk.c);
    wk_next.a = t1 + t2;
    wk_next.b = wk.a;
    wk_next.c = wk.b;
    wk_next.d = wk.c;
    wk_next.e = wk.d + t1;
    wk_next.f = wk.e;
    wk_next.g = wk.f;
    wk_next.h = wk.g;
  end

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 block controller: accepts padded blocks, runs ROUNDS rounds, chains H0..H7, returns digest.
//  state    | meaning
//  ST_IDLE  | waiting for a block; in_ready high
//  ST_LOAD  | copy H0..H7 into working regs, clear round counter
//  ST_ROUND | one compression round per cycle, schedule shifts
//  ST_FINAL | fold working regs into H0..H7
//  ST_DONE  | digest presented until out_ready
module sha256_round_ctrl
  import sha256_round_ctrl_pkg::*;
#(
  parameter int ROUNDS  = 64,
  parameter bit OUT_REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  input  logic         in_first,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_digest,
  output logic         busy
);

  state_t       state, state_nxt;
  work_t        wk, wk_next, h_st, h_sum;
  logic [31:0]  w_sched [16];
  logic [5:0]   rnd;
  logic [255:0] digest_q;
  logic         last_rnd;

  assign last_rnd = (rnd == 6'(ROUNDS - 1));

  sha256_round_ctrl_round u_round (
    .wk      (wk),
    .k       (K_TAB[rnd]),
    .w       (w_sched[0]),
    .wk_next (wk_next)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = ST_LOAD;
      end
      ST_LOAD:  state_nxt = ST_ROUND;
      ST_ROUND: if (last_rnd) state_nxt = ST_FINAL;
      ST_FINAL: state_nxt = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    h_sum.a = h_st.a + wk.a;
    h_sum.b = h_st.b + wk.b;
    h_sum.c = h_st.c + wk.c;
    h_sum.d = h_st.d + wk.d;
    h_sum.e = h_st.e + wk.e;
    h_sum.f = h_st.f + wk.f;
    h_sum.g = h_st.g + wk.g;
    h_sum.h = h_st.h + wk.h;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rnd      <= '0;
      h_st     <= IV;
      wk       <= '0;
      digest_q <= '0;
      for (int i = 0; i < 16; i++) w_sched[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          for (int i = 0; i < 16; i++) w_sched[i] <= in_block[511 - 32*i -: 32];
          if (in_first) h_st <= IV;
        end
        ST_LOAD: begin
          wk  <= h_st;
          rnd <= '0;
        end
        ST_ROUND: begin
          wk  <= wk_next;
          rnd <= rnd + 6'd1;
          // Only a 16-word window is kept; the next schedule word enters at the top.
          for (int i = 0; i < 15; i++) w_sched[i] <= w_sched[i+1];
          w_sched[15] <= small_sig1(w_sched[14]) + w_sched[9] + small_sig0(w_sched[1]) + w_sched[0];
        end
        ST_FINAL: begin
          h_st     <= h_sum;
          digest_q <= h_sum;
        end
        default: ;
      endcase
    end
  end

  assign out_digest = OUT_REG ? digest_q : h_st;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Self-checking bench for sha256_round_ctrl: known-answer vectors, stalls, reset, back-to-back, random blocks.
module tb_sha256_round_ctrl;
  import sha256_round_ctrl_pkg::K_TAB;

  localparam int ROUNDS = 64;
  localparam logic [255:0] REF_IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIG =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_DIG =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_block;
  logic         in_first;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_digest;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [511:0] blk_q [$];
  logic [255:0] model_h;

  always #5 clk = ~clk;

  sha256_round_ctrl #(.ROUNDS(ROUNDS), .OUT_REG(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_block   (in_block),
    .in_first   (in_first),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_digest (out_digest),
    .busy       (busy)
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook compression with the full 64-word expanded schedule.
  function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] hv [8];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] res;
    for (int i = 0; i < 8; i++) hv[i] = hin[255 - 32*i -: 32];
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int i = 0; i < 8; i++) v[i] = hv[i];
    for (int t = 0; t < ROUNDS; t++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TAB[t] + w[t];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hv[i] + v[i];
    return res;
  endfunction

  function automatic logic [255:0] model_block(input logic first, input logic [511:0] blk);
    if (first) model_h = REF_IV;
    model_h = ref_compress(model_h, blk);
    return model_h;
  endfunction

  task automatic pad_msg(input string s);
    byte unsigned b [$];
    logic [63:0]  len;
    logic [511:0] blk;
    blk_q.delete();
    for (int i = 0; i < s.len(); i++) b.push_back(s[i]);
    b.push_back(8'h80);
    while ((b.size() % 64) != 56) b.push_back(8'h00);
    len = 64'(s.len()) * 64'd8;
    for (int i = 7; i >= 0; i--) b.push_back(len[8*i +: 8]);
    for (int j = 0; j < b.size() / 64; j++) begin
      blk = '0;
      for (int i = 0; i < 64; i++) blk = {blk[503:0], b[64*j + i]};
      blk_q.push_back(blk);
    end
  endtask

  // Offer one block, measure latency, hold DONE for 'stall' cycles with junk on the input side, then handshake.
  task automatic send_block(input string tag, input logic [511:0] blk, input logic first,
                            input int stall, input logic [255:0] exp);
    int lat;
    logic [255:0] dig;
    in_block = blk;
    in_first = first;
    in_valid = 1'b1;
    lat = 0;
    while (!in_ready && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    check_eq({tag, "_ready"}, 256'(in_ready), 256'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_block = '0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    check_eq({tag, "_latency"}, 256'(lat), 256'(ROUNDS + 3));
    dig = out_digest;
    check_eq({tag, "_digest"}, dig, exp);
    check_eq({tag, "_busy_done"}, 256'({busy, in_ready}), 256'(2'b10));
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      in_first = 1'b1;
      in_block = {$urandom, $urandom, $urandom, $urandom, 384'h0};
      @(posedge clk); #1;
      check_eq({tag, "_stall_valid"}, 256'({out_valid, in_ready}), 256'(2'b10));
      check_eq({tag, "_stall_digest"}, out_digest, dig);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, "_post_hs"}, 256'({out_valid, in_ready, busy}), 256'(3'b010));
  endtask

  initial begin
    logic [255:0] exp;
    logic [511:0] blk;
    logic [511:0] abc_blk;
    int acc [$];
    int n_dig;
    int wait_n;

    rst = 1'b1; in_valid = 1'b0; in_block = '0; in_first = 1'b0; out_ready = 1'b0;
    model_h = REF_IV;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_flags", 256'({in_ready, out_valid, busy}), 256'(3'b100));
    check_eq("reset_digest", out_digest, 256'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Known-answer: "abc"
    pad_msg("abc");
    abc_blk = blk_q[0];
    exp = model_block(1'b1, abc_blk);
    send_block("abc", abc_blk, 1'b1, 0, ABC_DIG);

    // Known-answer: empty message
    pad_msg("");
    exp = model_block(1'b1, blk_q[0]);
    send_block("empty", blk_q[0], 1'b1, 2, EMPTY_DIG);

    // Two-block chained message, with a long DONE stall on block 1
    pad_msg("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    check_eq("two_nblocks", 256'(blk_q.size()), 256'(2));
    exp = model_block(1'b1, blk_q[0]);
    send_block("two_b1", blk_q[0], 1'b1, 10, exp);
    exp = model_block(1'b0, blk_q[1]);
    send_block("two_b2", blk_q[1], 1'b0, 0, TWO_DIG);

    // Reset around round 30, then chain request falls back to IV
    in_block = abc_blk; in_first = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (31) @(posedge clk);
    #1;
    check_eq("rst_mid_busy", 256'(busy), 256'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_mid_flags", 256'({in_ready, out_valid, busy}), 256'(3'b100));
    check_eq("rst_mid_digest", out_digest, 256'h0);
    rst = 1'b0;
    model_h = REF_IV;
    exp = model_block(1'b0, abc_blk);
    send_block("rst_abc", abc_blk, 1'b0, 1, ABC_DIG);

    // Back-to-back with both handshakes tied high
    in_block = abc_blk; in_first = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    n_dig = 0;
    for (int cyc = 0; cyc < 3 * (ROUNDS + 4); cyc++) begin
      if (in_valid && in_ready) acc.push_back(cyc);
      if (out_valid) begin
        check_eq("b2b_digest", out_digest, ABC_DIG);
        n_dig++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_eq("b2b_accepts", 256'(acc.size()), 256'(3));
    check_eq("b2b_digests", 256'(n_dig), 256'(3));
    for (int i = 1; i < acc.size(); i++)
      check_eq("b2b_interval", 256'(acc[i] - acc[i-1]), 256'(ROUNDS + 4));
    wait_n = 0;
    while ((busy || !in_ready) && wait_n < 200) begin
      @(posedge clk); #1; wait_n++;
    end
    check_eq("b2b_drain", 256'({busy, in_ready}), 256'(2'b01));
    out_ready = 1'b0;
    model_h = ABC_DIG;

    // Random blocks, random chaining and DONE stalls
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 16; i++) blk[511 - 32*i -: 32] = $urandom;
      in_first = 1'(($urandom_range(0, 2) == 0));
      exp = model_block(in_first, blk);
      send_block("rand", blk, in_first, $urandom_range(0, 3), exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
